// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button front end: channel FSM state
// encodings and the default timing parameters.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        REL     = 2'b00,
        REL_CHK = 2'b01,
        PRS     = 2'b10,
        PRS_CHK = 2'b11
    } key_state_e;

    // Board system clock, mirrored from the system parameter header.
    localparam int CLOCK_FREQ      = 50_000_000;
    localparam int DEBOUNCE_MS_DEF = 20;
    localparam int LONG_MS_DEF     = 1000;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, long-press timer and
// registered level/press/release/long outputs.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DB_CYC   = 4,
    parameter int LONG_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_W   = $clog2(DB_CYC);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);

    logic              sync0, sync1;
    key_state_e        state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt, hold_inc;
    logic              level_nxt, press_nxt, release_nxt, long_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0       <= 1'b0;
            sync1       <= 1'b0;
            state       <= REL;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            sync0       <= btn_in;
            sync1       <= sync0;
            state       <= state_nxt;
            db_cnt      <= db_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_long    <= long_nxt;
        end
    end

    // Saturating hold timer; reaching HOLD_MAX can only happen once per press.
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

    always_comb begin
        state_nxt    = state;
        db_cnt_nxt   = db_cnt;
        hold_cnt_nxt = hold_cnt;
        level_nxt    = btn_level;
        press_nxt    = 1'b0;
        release_nxt  = 1'b0;
        long_nxt     = 1'b0;
        case (state)
            REL: begin
                if (sync1) begin
                    state_nxt  = REL_CHK;
                    db_cnt_nxt = DB_ONE;
                end
            end
            REL_CHK: begin
                if (!sync1) begin
                    state_nxt  = REL;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt    = PRS;
                    db_cnt_nxt   = '0;
                    hold_cnt_nxt = '0;
                    level_nxt    = 1'b1;
                    press_nxt    = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end
            PRS: begin
                hold_cnt_nxt = hold_inc;
                long_nxt     = (hold_cnt == HOLD_PRE);
                if (!sync1) begin
                    state_nxt  = PRS_CHK;
                    db_cnt_nxt = DB_ONE;
                end
            end
            PRS_CHK: begin
                // Release bounce keeps the long timer running.
                hold_cnt_nxt = hold_inc;
                long_nxt     = (hold_cnt == HOLD_PRE);
                if (sync1) begin
                    state_nxt  = PRS;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt    = REL;
                    db_cnt_nxt   = '0;
                    hold_cnt_nxt = '0;
                    level_nxt    = 1'b0;
                    release_nxt  = 1'b1;
                    long_nxt     = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end
            default: begin
                state_nxt = REL;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button front end: N_KEYS independent debounced channels
// producing clean levels and press/release/long-press pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS      = 2,
    parameter int CLK_FREQ    = CLOCK_FREQ,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int LONG_MS     = LONG_MS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] btn_in,
    output logic [N_KEYS-1:0] btn_level,
    output logic [N_KEYS-1:0] btn_press,
    output logic [N_KEYS-1:0] btn_release,
    output logic [N_KEYS-1:0] btn_long
);

    localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;

    generate
        if (DB_CYC < 2) begin : g_bad_db
            $error("key_debounce: DB_CYC must be at least 2");
        end
        if (LONG_CYC <= DB_CYC) begin : g_bad_long
            $error("key_debounce: LONG_CYC must exceed DB_CYC");
        end
    endgenerate

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYC=4 and LONG_CYC=10.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_level, btn_press, btn_release, btn_long;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt_press[2]   = '{0, 0};
    int cnt_release[2] = '{0, 0};
    int cnt_long[2]    = '{0, 0};
    int snap_p0, snap_p1, snap_r0, snap_r1, snap_l1;

    key_debounce #(
        .N_KEYS      (2),
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cnt_press[i]   += int'(btn_press[i]);
            cnt_release[i] += int'(btn_release[i]);
            cnt_long[i]    += int'(btn_long[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                              input logic [1:0] rel, input logic [1:0] lng);
        check({tag, " level"},   32'(btn_level),   32'(lvl));
        check({tag, " press"},   32'(btn_press),   32'(prs));
        check({tag, " release"}, 32'(btn_release), 32'(rel));
        check({tag, " long"},    32'(btn_long),    32'(lng));
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 2'b00;
        tick(3);
        check_outs("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(3);

        // Clean press on channel 0: update on edge E0+5
        btn_in = 2'b01;
        tick(5);
        check_outs("clean E0+4", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        check_outs("clean E0+5", 2'b01, 2'b01, 2'b00, 2'b00);
        tick(1);
        check_outs("clean E0+6", 2'b01, 2'b00, 2'b00, 2'b00);
        btn_in = 2'b00;
        tick(5);
        check("clean rel E0+4", 32'(btn_level), 32'(2'b01));
        tick(1);
        check_outs("clean rel E0+5", 2'b00, 2'b00, 2'b01, 2'b00);
        tick(1);
        check("clean rel E0+6", 32'(btn_release), 32'(2'b00));
        check("clean no long", 32'(cnt_long[0]), 32'd0);
        tick(2);

        // Bounce 1,0,1,0 at 2-cycle intervals then stable 1
        snap_p0 = cnt_press[0];
        btn_in = 2'b01; tick(2);
        btn_in = 2'b00; tick(2);
        btn_in = 2'b01; tick(2);
        btn_in = 2'b00; tick(2);
        btn_in = 2'b01;
        tick(5);
        check("bounce E0+4 level", 32'(btn_level), 32'(2'b00));
        check("bounce no early press", 32'(cnt_press[0] - snap_p0), 32'd0);
        tick(1);
        check("bounce E0+5 press", 32'(btn_press), 32'(2'b01));
        tick(3);
        check("bounce press count", 32'(cnt_press[0] - snap_p0), 32'd1);
        btn_in = 2'b00;
        tick(8);
        check("bounce released", 32'(btn_level), 32'(2'b00));

        // Long press on channel 1, held 30 cycles
        snap_p1 = cnt_press[1];
        snap_r1 = cnt_release[1];
        snap_l1 = cnt_long[1];
        btn_in = 2'b10;
        tick(6);
        check_outs("long press P", 2'b10, 2'b10, 2'b00, 2'b00);
        tick(9);
        check("long P+9", 32'(btn_long), 32'(2'b00));
        tick(1);
        check_outs("long P+10", 2'b10, 2'b00, 2'b00, 2'b10);
        tick(1);
        check("long P+11", 32'(btn_long), 32'(2'b00));
        tick(13);
        check("long count", 32'(cnt_long[1] - snap_l1), 32'd1);
        btn_in = 2'b00;
        tick(6);
        check_outs("long release", 2'b00, 2'b00, 2'b10, 2'b00);
        tick(1);
        check("long release count", 32'(cnt_release[1] - snap_r1), 32'd1);
        check("long press count", 32'(cnt_press[1] - snap_p1), 32'd1);
        tick(2);

        // Independence: ch0 released on the same edge ch1 is pressed
        btn_in = 2'b01;
        tick(8);
        check("indep ch0 held", 32'(btn_level), 32'(2'b01));
        btn_in = 2'b10;
        tick(6);
        check_outs("indep swap", 2'b10, 2'b10, 2'b01, 2'b00);
        tick(1);

        // 3-cycle glitches on each channel
        snap_p0 = cnt_press[0];
        btn_in = 2'b11; tick(3);
        btn_in = 2'b10; tick(8);
        check("glitch ch0 press", 32'(cnt_press[0] - snap_p0), 32'd0);
        check("glitch ch0 level", 32'(btn_level), 32'(2'b10));
        snap_r1 = cnt_release[1];
        btn_in = 2'b00; tick(3);
        btn_in = 2'b10; tick(8);
        check("glitch ch1 release", 32'(cnt_release[1] - snap_r1), 32'd0);
        check("glitch ch1 level", 32'(btn_level), 32'(2'b10));

        // Asynchronous reset while both channels pressed
        btn_in = 2'b11;
        tick(8);
        check("pre-reset level", 32'(btn_level), 32'(2'b11));
        snap_r0 = cnt_release[0];
        snap_r1 = cnt_release[1];
        #2 rst = 1'b1;
        #1;
        check_outs("async reset", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        rst = 1'b0;
        tick(5);
        check_outs("post-reset E0+4", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        check_outs("post-reset E0+5", 2'b11, 2'b11, 2'b00, 2'b00);
        check("reset no release ch0", 32'(cnt_release[0] - snap_r0), 32'd0);
        check("reset no release ch1", 32'(cnt_release[1] - snap_r1), 32'd0);
        btn_in = 2'b00;
        tick(8);
        check("final release", 32'(btn_level), 32'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
